wb_stage_lsu: RTL and testbench

//  Writeback stage, next generation: the 5-stage CPU with decoupled load-data return.
//  MEM issues loads; read data returns in order over a valid/ready channel, 0..N cycles later.
//  The block buffers early responses, stalls WB until its load data is present, and aligns/extends load data.
//  It commits to the register file, feeds the bypass network, and discards responses of flushed loads.

---
 rtl/wb_pkg.sv | 26 ++
 rtl/wb_stage_lsu_if.sv | 48 ++++
 rtl/wb_resp_fifo.sv | 50 +++++
 rtl/wb_stage_lsu.sv | 155 +++++++++++++++
 tb/tb_wb_stage_lsu.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// wb_pkg : load-kind encodings and elaboration helpers for WB stage
// Rev 1.0
// ------------------------------------------------------------------
package wb_pkg;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;
    localparam logic [2:0] LD_LWL = 3'd5;
    localparam logic [2:0] LD_LWR = 3'd6;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_stage_lsu_if.sv
`default_nettype none
// ------------------------------------------------------------------
// wb_stage_lsu_if : MEM->WB, load-response, regfile and bypass signals
// Rev 1.0
// ------------------------------------------------------------------
interface wb_stage_lsu_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
);
    logic               mem_to_wb_valid;
    logic               wb_allowin;
    logic [31:0]        mem_pc;
    logic [RADDR_W-1:0] mem_dest;
    logic [3:0]         mem_wen;
    logic               mem_is_load;
    logic [2:0]         mem_ld_type;
    logic [1:0]         mem_vaddr_lo;
    logic [DATA_W-1:0]  mem_result;
    logic [DATA_W-1:0]  mem_rt_data;
    logic               data_rvalid;
    logic [DATA_W-1:0]  data_rdata;
    logic               data_rready;
    logic               wb_flush;
    logic [3:0]         rf_we;
    logic [RADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]  rf_wdata;
    logic               byp_valid;
    logic               byp_pending;
    logic [RADDR_W-1:0] byp_dest;
    logic [DATA_W-1:0]  byp_data;
    logic               wb_stage_valid;
    logic [31:0]        debug_wb_pc;

    modport master (
        output mem_to_wb_valid, mem_pc, mem_dest, mem_wen, mem_is_load, mem_ld_type,
               mem_vaddr_lo, mem_result, mem_rt_data, data_rvalid, data_rdata, wb_flush,
        input  wb_allowin, data_rready, rf_we, rf_waddr, rf_wdata, byp_valid,
               byp_pending, byp_dest, byp_data, wb_stage_valid, debug_wb_pc
    );

    modport slave (
        input  mem_to_wb_valid, mem_pc, mem_dest, mem_wen, mem_is_load, mem_ld_type,
               mem_vaddr_lo, mem_result, mem_rt_data, data_rvalid, data_rdata, wb_flush,
        output wb_allowin, data_rready, rf_we, rf_waddr, rf_wdata, byp_valid,
               byp_pending, byp_dest, byp_data, wb_stage_valid, debug_wb_pc
    );
endinterface
`default_nettype wire

// File: rtl/wb_resp_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// wb_resp_fifo : load-response buffer, pointers carry a wrap MSB
// Rev 1.0
// ------------------------------------------------------------------
module wb_resp_fifo
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_head
);
    localparam int PTR_W = clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W:0]    r_wptr;
    logic [PTR_W:0]    r_rptr;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign o_head  = r_mem[r_rptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + (PTR_W+1)'(1);
            if (i_pop)  r_rptr <= r_rptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr[PTR_W-1:0]] <= i_wdata;
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!resetn) !(i_push && o_full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!resetn) !(i_pop && o_empty));

endmodule
`default_nettype wire

// File: rtl/wb_stage_lsu.sv
`default_nettype none
// ------------------------------------------------------------------
// wb_stage_lsu : writeback stage with buffered in-order load returns
// Rev 1.0
// ------------------------------------------------------------------
module wb_stage_lsu
    import wb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int DEPTH   = 2
) (
    input  logic          clk,
    input  logic          resetn,
    wb_stage_lsu_if.slave bus
);
    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (DATA_W != 32) begin : g_chk_data_w
        $error("wb_stage_lsu: DATA_W must be 32");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("wb_stage_lsu: DEPTH must be a power of 2 and >= 2");
    end

    logic               r_wb_valid;
    logic [31:0]        r_pc;
    logic [RADDR_W-1:0] r_dest;
    logic [3:0]         r_wen;
    logic               r_is_load;
    logic [2:0]         r_ld_type;
    logic [1:0]         r_vaddr_lo;
    logic [DATA_W-1:0]  r_result;
    logic [DATA_W-1:0]  r_rt_data;
    logic [CNT_W-1:0]   r_drop_cnt;

    logic              w_full, w_empty;
    logic [DATA_W-1:0] w_fifo_head;
    logic              w_head_present, w_dropping, w_ready_go, w_fire;
    logic              w_pop_head, w_fifo_pop, w_push, w_allowin, w_drop_inc;
    logic [DATA_W-1:0] w_head_data, w_wdata;

    function automatic logic [31:0] f_align(input logic [2:0] t, input logic [1:0] v,
                                            input logic [31:0] m, input logic [31:0] r);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] y;
        b = m[{v, 3'b000} +: 8];
        h = v[1] ? m[31:16] : m[15:0];
        case (t)
            LD_LB:   y = {{24{b[7]}}, b};
            LD_LBU:  y = {24'd0, b};
            LD_LH:   y = {{16{h[15]}}, h};
            LD_LHU:  y = {16'd0, h};
            LD_LWL: begin
                case (v)
                    2'd0:    y = {m[7:0],  r[23:0]};
                    2'd1:    y = {m[15:0], r[15:0]};
                    2'd2:    y = {m[23:0], r[7:0]};
                    default: y = m;
                endcase
            end
            LD_LWR: begin
                case (v)
                    2'd0:    y = m;
                    2'd1:    y = {r[31:24], m[31:8]};
                    2'd2:    y = {r[31:16], m[31:16]};
                    default: y = {r[31:8],  m[31:24]};
                endcase
            end
            default: y = m;
        endcase
        return y;
    endfunction

    // An empty FIFO lets a same-cycle response feed WB directly.
    assign w_head_present = !w_empty || bus.data_rvalid;
    assign w_head_data    = w_empty ? bus.data_rdata : w_fifo_head;
    assign w_dropping     = (r_drop_cnt != '0) && w_head_present;
    assign w_ready_go     = !r_is_load || (w_head_present && (r_drop_cnt == '0));
    assign w_fire         = r_wb_valid && w_ready_go && !bus.wb_flush;
    assign w_pop_head     = w_dropping || (w_fire && r_is_load);
    assign w_fifo_pop     = w_pop_head && !w_empty;
    assign w_push         = bus.data_rvalid && !w_full && !(w_empty && w_pop_head);
    assign w_allowin      = !r_wb_valid || w_fire || bus.wb_flush;
    assign w_drop_inc     = r_wb_valid && r_is_load && bus.wb_flush;
    assign w_wdata        = r_is_load ? f_align(r_ld_type, r_vaddr_lo, w_head_data, r_rt_data)
                                      : r_result;

    wb_resp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_wdata (bus.data_rdata),
        .i_pop   (w_fifo_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_fifo_head)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wb_valid <= 1'b0;
            r_pc       <= '0;
            r_dest     <= '0;
            r_wen      <= '0;
            r_is_load  <= 1'b0;
            r_ld_type  <= LD_LW;
            r_vaddr_lo <= '0;
            r_result   <= '0;
            r_rt_data  <= '0;
        end else if (w_allowin) begin
            r_wb_valid <= bus.mem_to_wb_valid;
            if (bus.mem_to_wb_valid) begin
                r_pc       <= bus.mem_pc;
                r_dest     <= bus.mem_dest;
                r_wen      <= bus.mem_wen;
                r_is_load  <= bus.mem_is_load;
                r_ld_type  <= bus.mem_ld_type;
                r_vaddr_lo <= bus.mem_vaddr_lo;
                r_result   <= bus.mem_result;
                r_rt_data  <= bus.mem_rt_data;
            end
        end
    end

    // Each flushed, unserved load owes one response that must be discarded.
    always_ff @(posedge clk) begin
        if (!resetn) r_drop_cnt <= '0;
        else         r_drop_cnt <= r_drop_cnt + CNT_W'(w_drop_inc) - CNT_W'(w_dropping);
    end

    assign bus.wb_allowin     = w_allowin;
    assign bus.data_rready    = !w_full;
    assign bus.rf_we          = w_fire ? r_wen : 4'd0;
    assign bus.rf_waddr       = w_fire ? r_dest : '0;
    assign bus.rf_wdata       = w_fire ? w_wdata : '0;
    assign bus.byp_valid      = r_wb_valid && (r_wen != 4'd0);
    assign bus.byp_pending    = r_wb_valid && (r_wen != 4'd0) && r_is_load && !w_ready_go;
    assign bus.byp_dest       = r_dest;
    assign bus.byp_data       = w_wdata;
    assign bus.wb_stage_valid = r_wb_valid;
    assign bus.debug_wb_pc    = r_pc;

    a_drop_bound: assert property (@(posedge clk) disable iff (!resetn)
        r_drop_cnt <= CNT_W'(DEPTH));
    a_ld_type: assert property (@(posedge clk) disable iff (!resetn)
        (bus.mem_to_wb_valid && bus.mem_is_load) |-> (bus.mem_ld_type <= LD_LWR));

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_lsu.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_wb_stage_lsu : directed stimulus with a commit scoreboard
// Rev 1.0
// ------------------------------------------------------------------
module tb_wb_stage_lsu;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic resetn;

    wb_stage_lsu_if #(.DATA_W(32), .RADDR_W(5)) bus ();

    wb_stage_lsu #(.DATA_W(32), .RADDR_W(5), .DEPTH(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] pc       = 32'h0000_1000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic issue(input logic [4:0] dest, input logic ld, input logic [2:0] t,
                         input logic [1:0] v, input logic [31:0] res, input logic [31:0] rt);
        bus.mem_to_wb_valid = 1'b1;
        bus.mem_pc          = pc;
        bus.mem_dest        = dest;
        bus.mem_wen         = 4'hF;
        bus.mem_is_load     = ld;
        bus.mem_ld_type     = t;
        bus.mem_vaddr_lo    = v;
        bus.mem_result      = res;
        bus.mem_rt_data     = rt;
        pc                  = pc + 32'd4;
    endtask

    task automatic expect_wr(input logic [4:0] dest, input logic [31:0] data);
        sb.push_back('{we: 4'hF, addr: dest, data: data});
    endtask

    // Load into an empty WB, response returned on the cycle WB holds it.
    task automatic do_load(input logic [2:0] t, input logic [1:0] v, input logic [31:0] rt,
                           input logic [31:0] m, input logic [31:0] req, input logic [4:0] dest);
        issue(dest, 1'b1, t, v, 32'h0, rt);
        expect_wr(dest, req);
        tick();
        bus.mem_to_wb_valid = 1'b0;
        bus.data_rvalid     = 1'b1;
        bus.data_rdata      = m;
        sample();
        tick();
        bus.data_rvalid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1 && bus.rf_we != 4'h0) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL commit: unexpected write we=%h addr=%0d data=%h, required none",
                         bus.rf_we, bus.rf_waddr, bus.rf_wdata);
            end else begin
                mon_e = sb.pop_front();
                if (bus.rf_we !== mon_e.we || bus.rf_waddr !== mon_e.addr ||
                    bus.rf_wdata !== mon_e.data) begin
                    n_err++;
                    $display("FAIL commit: got we=%h addr=%0d data=%h, required we=%h addr=%0d data=%h",
                             bus.rf_we, bus.rf_waddr, bus.rf_wdata,
                             mon_e.we, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        resetn              = 1'b0;
        bus.mem_to_wb_valid = 1'b0;
        bus.mem_pc          = '0;
        bus.mem_dest        = '0;
        bus.mem_wen         = '0;
        bus.mem_is_load     = 1'b0;
        bus.mem_ld_type     = LD_LW;
        bus.mem_vaddr_lo    = '0;
        bus.mem_result      = '0;
        bus.mem_rt_data     = '0;
        bus.data_rvalid     = 1'b0;
        bus.data_rdata      = '0;
        bus.wb_flush        = 1'b0;
        tick();
        tick();
        sample();
        chk("reset_wb_valid", 32'(bus.wb_stage_valid), 32'd0);
        chk("reset_rf_we",    32'(bus.rf_we),          32'd0);
        chk("reset_rf_waddr", 32'(bus.rf_waddr),       32'd0);
        chk("reset_rf_wdata", bus.rf_wdata,            32'd0);
        chk("reset_rready",   32'(bus.data_rready),    32'd1);
        chk("reset_byp_valid", 32'(bus.byp_valid),     32'd0);
        tick();
        resetn = 1'b1;

        // ALU result commits in its first WB cycle
        issue(5'd3, 1'b0, LD_LW, 2'd0, 32'h0000_1234, 32'h0);
        expect_wr(5'd3, 32'h0000_1234);
        tick();
        bus.mem_to_wb_valid = 1'b0;
        sample();
        chk("alu_byp_valid", 32'(bus.byp_valid), 32'd1);
        chk("alu_byp_data",  bus.byp_data,       32'h0000_1234);
        tick();

        // LB with a response three cycles late
        issue(5'd5, 1'b1, LD_LB, 2'd2, 32'h0, 32'h0);
        expect_wr(5'd5, 32'hFFFF_FF80);
        tick();
        bus.mem_to_wb_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("lb_pending_wait", 32'(bus.byp_pending), 32'd1);
            tick();
        end
        bus.data_rvalid = 1'b1;
        bus.data_rdata  = 32'h0080_FF00;
        sample();
        chk("lb_pending_arrive", 32'(bus.byp_pending), 32'd0);
        tick();
        bus.data_rvalid = 1'b0;

        do_load(LD_LWL, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 32'hCCDD_3344, 5'd6);
        do_load(LD_LWR, 2'd2, 32'h1122_3344, 32'hAABB_CCDD, 32'h1122_AABB, 5'd7);
        do_load(LD_LHU, 2'd2, 32'h0,         32'h8001_FFFF, 32'h0000_8001, 5'd8);
        do_load(LD_LH,  2'd3, 32'h0,         32'h8001_FFFF, 32'hFFFF_8001, 5'd9);
        do_load(LD_LBU, 2'd1, 32'h0,         32'h0000_8000, 32'h0000_0080, 5'd10);
        do_load(LD_LWR, 2'd0, 32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_CCDD, 5'd11);

        // Two early responses fill the FIFO, then two loads drain it
        bus.data_rvalid = 1'b1;
        bus.data_rdata  = 32'h1111_1111;
        sample();
        chk("early_rready0", 32'(bus.data_rready), 32'd1);
        tick();
        bus.data_rdata = 32'h2222_2222;
        sample();
        chk("early_rready1", 32'(bus.data_rready), 32'd1);
        tick();
        bus.data_rvalid = 1'b0;
        issue(5'd12, 1'b1, LD_LW, 2'd0, 32'h0, 32'h0);
        expect_wr(5'd12, 32'h1111_1111);
        sample();
        chk("full_rready", 32'(bus.data_rready), 32'd0);
        tick();
        issue(5'd13, 1'b1, LD_LW, 2'd0, 32'h0, 32'h0);
        expect_wr(5'd13, 32'h2222_2222);
        sample();
        chk("full_pop_rready", 32'(bus.data_rready), 32'd0);
        chk("b2b_first_we",    32'(bus.rf_we),       32'hF);
        tick();
        bus.mem_to_wb_valid = 1'b0;
        sample();
        chk("b2b_second_we", 32'(bus.rf_we), 32'hF);
        tick();

        // Flush a waiting LHU; its response is discarded
        issue(5'd14, 1'b1, LD_LHU, 2'd0, 32'h0, 32'h0);
        tick();
        bus.mem_to_wb_valid = 1'b0;
        sample();
        chk("lhu_pending", 32'(bus.byp_pending), 32'd1);
        tick();
        bus.wb_flush = 1'b1;
        issue(5'd15, 1'b1, LD_LW, 2'd0, 32'h0, 32'h0);
        expect_wr(5'd15, 32'h0000_0002);
        sample();
        chk("flush_we", 32'(bus.rf_we), 32'd0);
        tick();
        bus.wb_flush        = 1'b0;
        bus.mem_to_wb_valid = 1'b0;
        bus.data_rvalid     = 1'b1;
        bus.data_rdata      = 32'h0000_0001;
        sample();
        chk("drop_we",      32'(bus.rf_we),       32'd0);
        chk("drop_pending", 32'(bus.byp_pending), 32'd1);
        tick();
        bus.data_rdata = 32'h0000_0002;
        sample();
        chk("post_drop_pending", 32'(bus.byp_pending), 32'd0);
        tick();
        bus.data_rvalid = 1'b0;
        do_load(LD_LW, 2'd0, 32'h0, 32'h0BAD_F00D, 32'h0BAD_F00D, 5'd16);

        // Reset while the FIFO holds one entry
        bus.data_rvalid = 1'b1;
        bus.data_rdata  = 32'hDEAD_BEEF;
        tick();
        bus.data_rvalid = 1'b0;
        resetn          = 1'b0;
        tick();
        resetn = 1'b1;
        sample();
        chk("mid_reset_wb_valid", 32'(bus.wb_stage_valid), 32'd0);
        chk("mid_reset_rf_we",    32'(bus.rf_we),          32'd0);
        chk("mid_reset_rready",   32'(bus.data_rready),    32'd1);
        tick();
        do_load(LD_LW, 2'd0, 32'h0, 32'h0000_0055, 32'h0000_0055, 5'd17);

        tick();
        tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
